// File: rtl/input_conditioner_pkg.sv
// Shared state encodings and helpers for the input conditioner's debounce FSM.
package input_conditioner_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'b00,
      CHECK_HIGH  = 2'b01,
      STABLE_HIGH = 2'b10,
      CHECK_LOW   = 2'b11
   } debounce_state_e;

   // The accepted output level is implied by the state alone.
   function automatic logic levelOf(debounce_state_e s);
      return (s == STABLE_HIGH) || (s == CHECK_LOW);
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing a one-cycle sample strobe every CLK_DIV enabled cycles.
module tick_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic Clock,
   input  logic Reset,
   input  logic Enable,
   output logic SampleTick
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] count_q, count_d;
   logic             atLast;

   always_comb begin
      atLast  = (count_q == CNT_LAST);
      count_d = count_q;
      if (Enable) begin
         count_d = atLast ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Gated with Reset so no strobe is visible while the block is held in reset.
   assign SampleTick = Enable & atLast & ~Reset;

endmodule

// File: rtl/input_conditioner.sv
// Synchronizes and debounces a raw external level; CleanOut changes only after
// DEBOUNCE_N consecutive agreeing sample ticks.
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int CLK_DIV    = 4,
   parameter int DEBOUNCE_N = 3
) (
   input  logic Clock,
   input  logic Reset,
   input  logic RawIn,
   input  logic Enable,
   output logic CleanOut,
   output logic SampleTick,
   output logic Changed
);

   localparam int AGREE_W = $clog2(DEBOUNCE_N + 1);
   localparam logic [AGREE_W-1:0] AGREE_ONE  = AGREE_W'(1);
   localparam logic [AGREE_W-1:0] AGREE_DONE = AGREE_W'(DEBOUNCE_N);

   logic                sync1_q, sync2_q;
   logic                tick;
   debounce_state_e     state_q, state_d;
   logic [AGREE_W-1:0]  agreeCnt_q, agreeCnt_d;
   logic [AGREE_W-1:0]  agreeNext;
   logic                cleanOut_q, cleanOut_d;
   logic                changed_q, changed_d;

   tick_gen #(
      .CLK_DIV(CLK_DIV)
   ) u_tick (
      .Clock     (Clock),
      .Reset     (Reset),
      .Enable    (Enable),
      .SampleTick(tick)
   );

   // Two-flop synchronizer; it keeps running even while Enable is low.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= RawIn;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      agreeCnt_d = agreeCnt_q;
      agreeNext  = agreeCnt_q + AGREE_ONE;
      case (state_q)
         STABLE_LOW: begin
            if (tick && sync2_q) begin
               state_d    = CHECK_HIGH;
               agreeCnt_d = AGREE_ONE;
            end
         end
         CHECK_HIGH: begin
            if (tick) begin
               if (!sync2_q) begin
                  state_d    = STABLE_LOW;
                  agreeCnt_d = '0;
               end else if (agreeNext == AGREE_DONE) begin
                  state_d    = STABLE_HIGH;
                  agreeCnt_d = '0;
               end else begin
                  agreeCnt_d = agreeNext;
               end
            end
         end
         STABLE_HIGH: begin
            if (tick && !sync2_q) begin
               state_d    = CHECK_LOW;
               agreeCnt_d = AGREE_ONE;
            end
         end
         CHECK_LOW: begin
            if (tick) begin
               if (sync2_q) begin
                  state_d    = STABLE_HIGH;
                  agreeCnt_d = '0;
               end else if (agreeNext == AGREE_DONE) begin
                  state_d    = STABLE_LOW;
                  agreeCnt_d = '0;
               end else begin
                  agreeCnt_d = agreeNext;
               end
            end
         end
         default: begin
            state_d    = STABLE_LOW;
            agreeCnt_d = '0;
         end
      endcase
      // Output level tracks the next state so CleanOut moves on the same edge as the state.
      cleanOut_d = levelOf(state_d);
      changed_d  = (cleanOut_d != cleanOut_q);
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q    <= STABLE_LOW;
         agreeCnt_q <= '0;
         cleanOut_q <= 1'b0;
         changed_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         agreeCnt_q <= agreeCnt_d;
         cleanOut_q <= cleanOut_d;
         changed_q  <= changed_d;
      end
   end

   assign CleanOut   = cleanOut_q;
   assign Changed    = changed_q;
   assign SampleTick = tick;

endmodule
